// File: rtl/elbeth_fwd_stall_unit_if.sv
// Operand-forwarding and stall-control signal bundle between the ELBETH pipeline
// and its forwarding/stall unit.
`timescale 1ns/1ps

interface elbeth_fwd_stall_unit_if #(
    parameter int unsigned NSRC  = 2,
    parameter int unsigned CNT_W = 16
);
    logic [5*NSRC-1:0] id_rs_addr;
    logic [NSRC-1:0]   id_rs_used;
    logic [4:0]        ex_rd_addr;
    logic              ex_w_gpr_en;
    logic              ex_mem_rd;
    logic [4:0]        mem_rd_addr;
    logic              mem_w_gpr_en;
    logic              mem_mem_en;
    logic              mem_ready;
    logic [4:0]        wb_rd_addr;
    logic              wb_w_gpr_en;
    logic              perf_clr;

    logic [2*NSRC-1:0] fwd_sel;
    logic              stall_if;
    logic              stall_id;
    logic              stall_ex;
    logic              bubble_ex;
    logic              bubble_wb;
    logic [CNT_W-1:0]  perf_stall_cnt;

    // Pipeline side: drives hazard inputs, consumes controls.
    modport master (
        output id_rs_addr, id_rs_used,
        output ex_rd_addr, ex_w_gpr_en, ex_mem_rd,
        output mem_rd_addr, mem_w_gpr_en, mem_mem_en, mem_ready,
        output wb_rd_addr, wb_w_gpr_en, perf_clr,
        input  fwd_sel, stall_if, stall_id, stall_ex, bubble_ex, bubble_wb, perf_stall_cnt
    );

    // Forwarding/stall unit side.
    modport slave (
        input  id_rs_addr, id_rs_used,
        input  ex_rd_addr, ex_w_gpr_en, ex_mem_rd,
        input  mem_rd_addr, mem_w_gpr_en, mem_mem_en, mem_ready,
        input  wb_rd_addr, wb_w_gpr_en, perf_clr,
        output fwd_sel, stall_if, stall_id, stall_ex, bubble_ex, bubble_wb, perf_stall_cnt
    );
endinterface

// File: rtl/elbeth_fwd_stall_unit.sv
// ELBETH 5-stage pipeline forwarding/stall controller: per-operand bypass select,
// load-use and data-memory wait stall sequencing, saturating stall-cycle counter.
`timescale 1ns/1ps

module elbeth_fwd_stall_unit #(
    parameter int unsigned NSRC     = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    elbeth_fwd_stall_unit_if.slave bus
);

    typedef enum logic [1:0] {
        StRun,
        StLoadUse,
        StMemWait
    } state_e;

    localparam logic [2:0] LuInit  = 3'(LOAD_LAT - 1);
    localparam bit         LuMulti = (LOAD_LAT > 1);

    state_e           state_q, state_d;
    logic [2:0]       lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0] perf_q;

    logic [NSRC-1:0]   m_ex, m_mem, m_wb;
    logic [2*NSRC-1:0] fwd_raw;
    logic              lu, mb;
    logic              s_if, s_id, s_ex, b_ex, b_wb;

    // Operand match and bypass priority; an EX load cannot forward, so it falls through.
    always_comb begin
        m_ex    = '0;
        m_mem   = '0;
        m_wb    = '0;
        fwd_raw = '0;
        for (int i = 0; i < int'(NSRC); i++) begin
            logic [4:0] rs;
            logic       live;
            rs   = bus.id_rs_addr[5*i +: 5];
            live = bus.id_rs_used[i] && (rs != 5'd0);
            m_ex[i]  = live && bus.ex_w_gpr_en  && (bus.ex_rd_addr  == rs);
            m_mem[i] = live && bus.mem_w_gpr_en && (bus.mem_rd_addr == rs);
            m_wb[i]  = live && bus.wb_w_gpr_en  && (bus.wb_rd_addr  == rs);
            if (m_ex[i] && !bus.ex_mem_rd) begin
                fwd_raw[2*i +: 2] = 2'b01;
            end else if (m_mem[i]) begin
                fwd_raw[2*i +: 2] = 2'b10;
            end else if (m_wb[i]) begin
                fwd_raw[2*i +: 2] = 2'b11;
            end
        end
    end

    assign lu = (|m_ex) && bus.ex_mem_rd;
    assign mb = bus.mem_mem_en && !bus.mem_ready;

    always_comb begin
        logic do_run;
        state_d  = state_q;
        lu_cnt_d = lu_cnt_q;
        s_if     = 1'b0;
        s_id     = 1'b0;
        s_ex     = 1'b0;
        b_ex     = 1'b0;
        b_wb     = 1'b0;
        do_run   = 1'b0;

        unique case (state_q)
            StRun: begin
                do_run = 1'b1;
            end
            StLoadUse: begin
                if (mb) begin
                    s_if    = 1'b1;
                    s_id    = 1'b1;
                    s_ex    = 1'b1;
                    b_wb    = 1'b1;
                    state_d = StMemWait;
                end else begin
                    s_if     = 1'b1;
                    s_id     = 1'b1;
                    b_ex     = 1'b1;
                    lu_cnt_d = lu_cnt_q - 3'd1;
                    if (lu_cnt_q == 3'd1) begin
                        state_d = StRun;
                    end
                end
            end
            StMemWait: begin
                if (mb) begin
                    s_if = 1'b1;
                    s_id = 1'b1;
                    s_ex = 1'b1;
                    b_wb = 1'b1;
                end else if (lu_cnt_q != 3'd0) begin
                    // Interrupted load-use resumes with its remaining count.
                    state_d = StLoadUse;
                    if (lu) begin
                        s_if = 1'b1;
                        s_id = 1'b1;
                        b_ex = 1'b1;
                    end
                end else begin
                    do_run = 1'b1;
                end
            end
            default: begin
                state_d  = StRun;
                lu_cnt_d = 3'd0;
            end
        endcase

        if (do_run) begin
            if (mb) begin
                s_if    = 1'b1;
                s_id    = 1'b1;
                s_ex    = 1'b1;
                b_wb    = 1'b1;
                state_d = StMemWait;
            end else if (lu) begin
                s_if     = 1'b1;
                s_id     = 1'b1;
                b_ex     = 1'b1;
                lu_cnt_d = LuInit;
                state_d  = LuMulti ? StLoadUse : StRun;
            end else begin
                state_d = StRun;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StRun;
            lu_cnt_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            lu_cnt_q <= lu_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (bus.perf_clr) begin
            perf_q <= '0;
        end else if (s_id && (perf_q != {CNT_W{1'b1}})) begin
            perf_q <= perf_q + CNT_W'(1);
        end
    end

    // Controls are held low for the whole reset window, so a stall in flight dies at once.
    assign bus.fwd_sel        = rst_n ? fwd_raw : '0;
    assign bus.stall_if       = rst_n && s_if;
    assign bus.stall_id       = rst_n && s_id;
    assign bus.stall_ex       = rst_n && s_ex;
    assign bus.bubble_ex      = rst_n && b_ex;
    assign bus.bubble_wb      = rst_n && b_wb;
    assign bus.perf_stall_cnt = perf_q;

endmodule

// File: tb/tb_elbeth_fwd_stall_unit.sv
// Directed scoreboard bench for elbeth_fwd_stall_unit (NSRC=2, LOAD_LAT=3, CNT_W=4).
`timescale 1ns/1ps

module tb_elbeth_fwd_stall_unit;

    localparam int unsigned NSRC     = 2;
    localparam int unsigned LOAD_LAT = 3;
    localparam int unsigned CNT_W    = 4;

    // Control vector order: {stall_if, stall_id, stall_ex, bubble_ex, bubble_wb}
    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_LU   = 5'b11010;
    localparam logic [4:0] C_MW   = 5'b11101;

    typedef struct {
        string      tag;
        logic [3:0] fwd;
        logic [4:0] ctl;
        logic [3:0] perf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   perf_model = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    elbeth_fwd_stall_unit_if #(.NSRC(NSRC), .CNT_W(CNT_W)) bus ();

    elbeth_fwd_stall_unit #(
        .NSRC    (NSRC),
        .LOAD_LAT(LOAD_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.id_rs_addr   = '0;
        bus.id_rs_used   = '0;
        bus.ex_rd_addr   = '0;
        bus.ex_w_gpr_en  = 1'b0;
        bus.ex_mem_rd    = 1'b0;
        bus.mem_rd_addr  = '0;
        bus.mem_w_gpr_en = 1'b0;
        bus.mem_mem_en   = 1'b0;
        bus.mem_ready    = 1'b0;
        bus.wb_rd_addr   = '0;
        bus.wb_w_gpr_en  = 1'b0;
        bus.perf_clr     = 1'b0;
    endtask

    // Called at a falling edge with inputs already driven; checks, then advances one cycle.
    task automatic step(input string tag, input logic [3:0] fwd, input logic [4:0] ctl);
        exp_t e;
        if (!rst_n) perf_model = 0;
        sb.push_back('{tag: tag, fwd: fwd, ctl: ctl, perf: 4'(perf_model)});
        #2;
        e = sb.pop_front();
        chk({e.tag, "_fwd"}, 32'(bus.fwd_sel), 32'(e.fwd));
        chk({e.tag, "_ctl"}, 32'({bus.stall_if, bus.stall_id, bus.stall_ex,
                                  bus.bubble_ex, bus.bubble_wb}), 32'(e.ctl));
        chk({e.tag, "_perf"}, 32'(bus.perf_stall_cnt), 32'(e.perf));
        @(posedge clk);
        if (!rst_n || bus.perf_clr) perf_model = 0;
        else if (ctl[3] && perf_model < 15) perf_model++;
        @(negedge clk);
    endtask

    task automatic load_use_setup();
        idle();
        bus.id_rs_addr  = {5'd7, 5'd0};
        bus.id_rs_used  = 2'b10;
        bus.ex_rd_addr  = 5'd7;
        bus.ex_w_gpr_en = 1'b1;
        bus.ex_mem_rd   = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        @(negedge clk);

        // Reset forces forwarding selects low even with a live match.
        bus.id_rs_addr  = {5'd0, 5'd5};
        bus.id_rs_used  = 2'b01;
        bus.ex_rd_addr  = 5'd5;
        bus.ex_w_gpr_en = 1'b1;
        step("rst_fwd", 4'b0000, C_NONE);
        rst_n = 1'b1;

        // Bypass priority EX > MEM > WB.
        bus.mem_rd_addr  = 5'd5;
        bus.mem_w_gpr_en = 1'b1;
        bus.wb_rd_addr   = 5'd5;
        bus.wb_w_gpr_en  = 1'b1;
        step("fwd_ex", 4'b0001, C_NONE);
        bus.ex_w_gpr_en = 1'b0;
        step("fwd_mem", 4'b0010, C_NONE);
        bus.mem_w_gpr_en = 1'b0;
        step("fwd_wb", 4'b0011, C_NONE);
        bus.ex_w_gpr_en  = 1'b1;
        bus.id_rs_addr   = {5'd9, 5'd5};
        bus.id_rs_used   = 2'b11;
        bus.mem_rd_addr  = 5'd9;
        bus.mem_w_gpr_en = 1'b1;
        step("fwd_both", 4'b1001, C_NONE);

        // r0 never forwards; unused operand never forwards or stalls.
        idle();
        bus.id_rs_used  = 2'b01;
        bus.ex_w_gpr_en = 1'b1;
        step("rs_zero", 4'b0000, C_NONE);
        bus.id_rs_addr = {5'd7, 5'd0};
        bus.ex_rd_addr = 5'd7;
        bus.ex_mem_rd  = 1'b1;
        step("rs_unused", 4'b0000, C_NONE);

        // Load-use: exactly LOAD_LAT stall cycles; MEM bypass stays visible.
        load_use_setup();
        bus.mem_rd_addr  = 5'd7;
        bus.mem_w_gpr_en = 1'b1;
        step("lu1", 4'b1000, C_LU);
        bus.ex_w_gpr_en = 1'b0;
        bus.ex_mem_rd   = 1'b0;
        step("lu2", 4'b1000, C_LU);
        step("lu3", 4'b1000, C_LU);
        step("lu_done", 4'b1000, C_NONE);
        chk("lu_perf3", 32'(bus.perf_stall_cnt), 32'd3);

        // Memory wait for four cycles, released on the ready cycle.
        idle();
        bus.mem_mem_en = 1'b1;
        for (int i = 0; i < 4; i++) step("mw", 4'b0000, C_MW);
        bus.mem_ready = 1'b1;
        step("mw_ready", 4'b0000, C_NONE);

        // Memory wait interrupts a load-use stall; the remaining load-use cycles resume.
        load_use_setup();
        step("lumw_lu1", 4'b0000, C_LU);
        idle();
        bus.mem_mem_en = 1'b1;
        step("lumw_w1", 4'b0000, C_MW);
        step("lumw_w2", 4'b0000, C_MW);
        bus.mem_ready = 1'b1;
        step("lumw_exit", 4'b0000, C_NONE);
        idle();
        step("lumw_lu2", 4'b0000, C_LU);
        step("lumw_lu3", 4'b0000, C_LU);
        step("lumw_done", 4'b0000, C_NONE);
        chk("lumw_perf12", 32'(bus.perf_stall_cnt), 32'd12);

        // Clear wins over a concurrent stall increment.
        bus.mem_mem_en = 1'b1;
        bus.perf_clr   = 1'b1;
        step("clr_stall", 4'b0000, C_MW);
        idle();
        step("clr_after", 4'b0000, C_NONE);

        // Reset in the middle of a load-use stall.
        load_use_setup();
        step("rlu1", 4'b0000, C_LU);
        idle();
        step("rlu2", 4'b0000, C_LU);
        rst_n = 1'b0;
        bus.id_rs_addr  = {5'd0, 5'd5};
        bus.id_rs_used  = 2'b01;
        bus.ex_rd_addr  = 5'd5;
        bus.ex_w_gpr_en = 1'b1;
        step("rst_mid", 4'b0000, C_NONE);
        rst_n = 1'b1;
        idle();
        step("post_rst", 4'b0000, C_NONE);
        load_use_setup();
        step("plu1", 4'b0000, C_LU);
        idle();
        step("plu2", 4'b0000, C_LU);
        step("plu3", 4'b0000, C_LU);
        step("plu_done", 4'b0000, C_NONE);

        // Counter saturates at all-ones.
        bus.mem_mem_en = 1'b1;
        for (int i = 0; i < 15; i++) step("sat", 4'b0000, C_MW);
        bus.mem_ready = 1'b1;
        step("sat_done", 4'b0000, C_NONE);
        chk("sat_perf15", 32'(bus.perf_stall_cnt), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
